seq_multiplier: RTL
===================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; the adder datapath and the shift registers are WIDTH bits wide.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request; sampled on rising edge of clk.
REQ-005 A  input  WIDTH  unsigned multiplicand; captured when Start is accepted.
REQ-006 B  input  WIDTH  unsigned multiplier; captured when Start is accepted.
REQ-007 Product  output  2*WIDTH  registered result of the last completed operation.
REQ-008 Busy  output  1  high while an operation is in progress (RUN state).
REQ-009 Done  output  1  one-cycle pulse; Product is newly valid in that cycle.

Function
REQ-010 FSM states: IDLE, RUN, DONE; Busy = (state==RUN); Done = (state==DONE); both are decoded from the state register.
REQ-011 Internal registers: M (WIDTH), Q (WIDTH), Acc (WIDTH), carry C (1), iteration counter Cnt (clog2(WIDTH) bits, minimum 1).
REQ-012 IDLE with Start=1 at an edge: M<=A, Q<=B, Acc<=0, C<=0, Cnt<=0, state<=RUN.
REQ-013 IDLE with Start=0: all registers hold.
REQ-014 RUN, each edge: {C,Acc} = Acc + (Q[0] ? M : 0), computed as a (WIDTH+1)-bit unsigned sum; then {C,Acc,Q} shifts right by one bit, C<=0, and Cnt<=Cnt+1.
REQ-015 RUN at the edge where Cnt==WIDTH-1: perform the REQ-014 step, write Product<={Acc,Q} using the post-shift values, and set state<=DONE.
REQ-016 Latency: Start is accepted at edge k; Busy is high for cycles k..k+WIDTH-1; Done is high for exactly one cycle after edge k+WIDTH.
REQ-017 Start is ignored while in RUN; A and B may change freely during RUN without affecting the result.
REQ-018 DONE with Start=1: load as in REQ-012 and go to RUN, so back-to-back operations add no idle cycle.
REQ-019 DONE with Start=0: go to IDLE.
REQ-020 Product changes only at the REQ-015 edge and during reset; it holds its previous value throughout a new RUN.
REQ-021 The result is exact: Product = A*B mod 2^(2*WIDTH), with no overflow possible; the adder carry C is folded into the shift so that it is never lost.
REQ-022 Cnt does not wrap during RUN; its value is don't-care outside RUN.

Reset
REQ-023 On rst=1, asynchronously: state<=IDLE, Product<=0, M, Q, Acc, C and Cnt<=0; therefore Busy=0 and Done=0.
REQ-024 Reset asserted mid-RUN aborts the operation: no Done pulse, and Product reads 0.
REQ-025 After rst deasserts, the first edge with Start=1 is accepted per REQ-012.

Verification
REQ-026 rst pulse, then A=3, B=5, Start for 1 cycle -> Busy high 4 cycles, then Done for 1 cycle with Product=8'h0F.
REQ-027 A=15, B=15 (exercises the carry path) -> Product=8'hE1 (225) at Done.
REQ-028 A=0, B=9 -> Product=8'h00; then A=9, B=0 -> Product=8'h00; the Done pulse occurs on schedule in both cases.
REQ-029 Start A=2, B=6; during RUN drive Start=1 with A=7, B=7 -> that Start is ignored and Product=8'h0C; a Start held high in the DONE cycle with A=7, B=7 begins a new run immediately -> next Product=8'h31.
REQ-030 Start A=13, B=11; assert rst in the 2nd Busy cycle -> Busy and Done drop immediately, Product=0, no Done pulse; after release, A=13, B=11 -> Product=8'h8F (143).
REQ-031 Every test: Product equals the A*B reference model at each Done pulse; Done is never high for more than 1 consecutive cycle; Busy and Done are never high together.

Source files
------------

// File: rtl/seq_multiplier.sv
// Shift-and-add unsigned multiplier: WIDTH RUN cycles per operation, then a one-cycle Done pulse.
// Start is ignored while busy; a Start in the DONE cycle chains the next operation with no idle cycle.
module seq_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic [2*WIDTH-1:0]   Product,
   output logic                 Busy,
   output logic                 Done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] m, q, acc;
   logic             c;
   logic [CW-1:0]    cnt;

   logic             load, last;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] acc_sh, q_sh;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (Start) state_nxt = RUN;
         RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
         DONE:    state_nxt = Start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Busy = (state == RUN);
      Done = (state == DONE);
      load = (state != RUN) && Start;
      last = (state == RUN) && (cnt == CW'(WIDTH - 1));
   end

   // Carry lands in the top of the shifted word, so the full sum survives each step.
   always_comb begin
      sum    = {c, acc} + {1'b0, (q[0] ? m : {WIDTH{1'b0}})};
      acc_sh = sum[WIDTH:1];
      q_sh   = {sum[0], q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m       <= '0;
         q       <= '0;
         acc     <= '0;
         c       <= 1'b0;
         cnt     <= '0;
         Product <= '0;
      end else if (load) begin
         m   <= A;
         q   <= B;
         acc <= '0;
         c   <= 1'b0;
         cnt <= '0;
      end else if (state == RUN) begin
         acc <= acc_sh;
         q   <= q_sh;
         c   <= 1'b0;
         cnt <= cnt + CW'(1);
         if (last) Product <= {acc_sh, q_sh};
      end
   end

endmodule
